// File: rtl/instruction_sequencer.sv
// Issues up to 32 stored 13-bit instruction words, inserting GAP idle cycles after each one.
// Build macro SEQ_LOOP_EN: a run wraps to the first instruction instead of finishing in DONE.
module instruction_sequencer #(
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prog_we,
    input  logic [4:0]  prog_addr,
    input  logic [12:0] prog_data,
    input  logic [5:0]  prog_len,
    input  logic        start,
    input  logic        stop,
    input  logic        stall,
    output logic [12:0] instruction,
    output logic        instr_valid,
    output logic [4:0]  pc,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef SEQ_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    localparam logic [3:0] GAP_CYC = 4'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [12:0] instr_q, instr_d;
    logic [3:0]  gap_q, gap_d;
    logic [5:0]  len_q, len_d;
    logic        valid_q, busy_q, done_q;
    logic        err_q, err_d;
    logic [12:0] mem_q [32];

    logic        issue_s;
    logic [4:0]  issue_addr_s;
    logic        last_s;
    logic        idle_s;
    logic [5:0]  len_clamp_s;

    // Next-state logic: decides when the next word issues, when the run ends, and error flagging.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        gap_d       = gap_q;
        len_d       = len_q;
        issue_s     = 1'b0;
        idle_s      = (state_q == ST_IDLE) || (state_q == ST_DONE);
        last_s      = ({1'b0, pc_q} == (len_q - 6'd1));
        len_clamp_s = (prog_len > 6'd32) ? 6'd32 : prog_len;
        if (last_s) begin
            issue_addr_s = 5'd0;
        end else begin
            issue_addr_s = pc_q + 5'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !stop) begin
                    if (prog_len == 6'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        len_d        = len_clamp_s;
                        issue_addr_s = 5'd0;
                        issue_s      = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_ISSUE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (GAP_CYC != 4'd0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_CYC - 4'd1;
                end else if (last_s && !LOOP_EN) begin
                    state_d = ST_DONE;
                end else if (stall) begin
                    // Zero-gap stall parks in GAP with an expired count so the issue is retried next edge.
                    state_d = ST_GAP;
                    gap_d   = 4'd0;
                end else begin
                    issue_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (last_s && !LOOP_EN) begin
                    state_d = ST_DONE;
                end else if (stall) begin
                    state_d = ST_GAP;
                end else begin
                    issue_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_s) begin
            state_d = ST_ISSUE;
            pc_d    = issue_addr_s;
            instr_d = mem_q[issue_addr_s];
        end else begin
            pc_d    = pc_q;
        end

        err_d = err_q || (prog_we && !idle_s);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= 5'd0;
            instr_q <= 13'h0000;
            gap_q   <= 4'd0;
            len_q   <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            gap_q   <= gap_d;
            len_q   <= len_d;
            valid_q <= issue_s;
            busy_q  <= (state_d == ST_ISSUE) || (state_d == ST_GAP);
            done_q  <= (state_d == ST_DONE);
            err_q   <= err_d;
        end
    end

    // Program memory keeps its contents across reset; writes only land while not running.
    always_ff @(posedge clk) begin
        if (prog_we && idle_s && !reset) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Drives a GAP=1 and a GAP=0 sequencer with shared stimulus and compares both against a timestamp-based model.
module tb_instruction_sequencer;

`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, prog_we, start, stop, stall;
    logic [4:0]  prog_addr;
    logic [12:0] prog_data;
    logic [5:0]  prog_len;

    logic [1:0][12:0] instr_w;
    logic [1:0][4:0]  pc_w;
    logic [1:0]       valid_w, busy_w, done_w, err_w;

    instruction_sequencer #(.GAP(1)) u_dut_g1 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .stop(stop),
        .stall(stall), .instruction(instr_w[0]), .instr_valid(valid_w[0]),
        .pc(pc_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    instruction_sequencer #(.GAP(0)) u_dut_g0 (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start), .stop(stop),
        .stall(stall), .instruction(instr_w[1]), .instr_valid(valid_w[1]),
        .pc(pc_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;

    // Reference model: per instance, run/done flags plus the timestamp of the last issue.
    logic [12:0] m_mem [2][32];
    logic [12:0] m_instr [2];
    bit          m_run [2], m_done [2], m_valid [2], m_err [2];
    int          m_pc [2], m_len [2], m_last_t [2];

    logic [12:0] basic_prog [4] = '{13'h0005, 13'h0A01, 13'h1000, 13'h0E07};
    int          cyc_q [$];
    logic [12:0] word_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, t);
        end
    endtask

    function automatic void model_issue(input int k, input int a);
        m_pc[k]     = a;
        m_instr[k]  = m_mem[k][a];
        m_valid[k]  = 1'b1;
        m_last_t[k] = t;
        m_run[k]    = 1'b1;
        m_done[k]   = 1'b0;
    endfunction

    task automatic model_edge(input int k);
        int gap;
        bit wr_ok;
        gap        = (k == 0) ? 1 : 0;
        m_valid[k] = 1'b0;
        if (reset) begin
            m_run[k]   = 1'b0;
            m_done[k]  = 1'b0;
            m_pc[k]    = 0;
            m_instr[k] = 13'h0000;
            m_err[k]   = 1'b0;
            return;
        end
        wr_ok = prog_we && !m_run[k];
        if (prog_we && m_run[k]) m_err[k] = 1'b1;
        if (!m_run[k]) begin
            if (start && !stop) begin
                if (prog_len == 6'd0) m_done[k] = 1'b1;
                else begin
                    m_len[k] = (prog_len > 6'd32) ? 32 : int'(prog_len);
                    model_issue(k, 0);
                end
            end
        end else if (stop) begin
            m_run[k]  = 1'b0;
            m_done[k] = 1'b0;
        end else if (t - m_last_t[k] > gap) begin
            // All gap cycles since the last issue have elapsed.
            if (m_pc[k] == m_len[k] - 1 && !LOOP) begin
                m_run[k]  = 1'b0;
                m_done[k] = 1'b1;
            end else if (!stall) begin
                model_issue(k, (m_pc[k] == m_len[k] - 1) ? 0 : m_pc[k] + 1);
            end
        end
        if (wr_ok) m_mem[k][prog_addr] = prog_data;
    endtask

    task automatic step(input bit we, input logic [4:0] a, input logic [12:0] d,
                        input logic [5:0] len, input bit st, input bit sp,
                        input bit sl, input bit rs);
        prog_we = we; prog_addr = a; prog_data = d; prog_len = len;
        start = st; stop = sp; stall = sl; reset = rs;
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        t++;
        for (int k = 0; k < 2; k++) begin
            string g;
            g = (k == 0) ? "g1" : "g0";
            chk({g, "_valid"}, 32'(valid_w[k]), 32'(m_valid[k]));
            chk({g, "_instr"}, 32'(instr_w[k]), 32'(m_instr[k]));
            chk({g, "_pc"},    32'(pc_w[k]),    32'(m_pc[k]));
            chk({g, "_busy"},  32'(busy_w[k]),  32'(m_run[k]));
            chk({g, "_done"},  32'(done_w[k]),  32'(m_done[k]));
            chk({g, "_err"},   32'(err_w[k]),   32'(m_err[k]));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 13'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input logic [5:0] len);
        step(1'b0, 5'd0, 13'd0, len, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic halt();
        step(1'b0, 5'd0, 13'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 5'd0, 13'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 13'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++)
            step(1'b1, 5'(i), (i < 4) ? basic_prog[i] : 13'($urandom), 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic run on the GAP=1 instance: pulses on cycles 1,3,5,7.
        go(6'd4);
        for (int c = 1; c <= 8; c++) begin
            if (valid_w[0]) begin cyc_q.push_back(c); word_q.push_back(instr_w[0]); end
            idle(1);
        end
        chk("basic_count", 32'(cyc_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cyc_q.size()) begin
                chk("basic_cycle", 32'(cyc_q[i]), 32'(2 * i + 1));
                chk("basic_word", 32'(word_q[i]), 32'(basic_prog[i]));
            end
        end
        halt();

        // Stall on the GAP=0 instance: second issue slips from cycle 2 to cycle 4.
        cyc_q.delete();
        go(6'd3);
        for (int c = 1; c <= 5; c++) begin
            if (valid_w[1]) cyc_q.push_back(c);
            step(1'b0, 5'd0, 13'd0, 6'd0, 1'b0, 1'b0, c <= 2, 1'b0);
        end
        chk("stall_count", 32'(cyc_q.size()), 32'd3);
        if (cyc_q.size() == 3) begin
            chk("stall_c0", 32'(cyc_q[0]), 32'd1);
            chk("stall_c1", 32'(cyc_q[1]), 32'd4);
            chk("stall_c2", 32'(cyc_q[2]), 32'd5);
        end
        halt();

        // Stop during the second gap, then start and stop together while idle.
        go(6'd4);
        idle(3);
        halt();
        chk("stop_busy", 32'(busy_w[0]), 32'd0);
        chk("stop_done", 32'(done_w[0]), 32'd0);
        chk("stop_pc", 32'(pc_w[0]), 32'd1);
        step(1'b0, 5'd0, 13'd0, 6'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("startstop_busy", 32'(busy_w[0]), 32'd0);
        chk("startstop_valid", 32'(valid_w[0]), 32'd0);

        // Program write while busy is dropped and flags err.
        go(6'd4);
        step(1'b1, 5'd0, 13'h1FFF, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);
        halt();
        chk("err_sticky", 32'(err_w[0]), 32'd1);
        go(6'd4);
        chk("rerun_word", 32'(instr_w[0]), 32'h0005);
        halt();

        // Reset mid-run at pc=2 on the GAP=1 instance.
        go(6'd4);
        idle(4);
        chk("pre_reset_pc", 32'(pc_w[0]), 32'd2);
        step(1'b0, 5'd0, 13'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_instr", 32'(instr_w[0]), 32'h0000);
        chk("rst_err", 32'(err_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        go(6'd4);
        chk("post_rst_word", 32'(instr_w[0]), 32'h0005);
        idle(9);
        halt();

        // Zero length, two-word loop candidate, and an oversize length.
        go(6'd0);
        chk("len0_done", 32'(done_w[0]), 32'd1);
        chk("len0_valid", 32'(valid_w[1]), 32'd0);
        go(6'd2);
        idle(6);
        halt();
        go(6'd40);
        idle(70);
        halt();

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 19) == 0, 5'($urandom), 13'($urandom),
                 6'($urandom_range(0, 40)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 149) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter GAP, default 1, SHALL set the idle cycles inserted after each issued instruction (legal range 0..15).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port prog_we  input  1  SHALL be the program-memory write strobe.
REQ-005 Port prog_addr  input  5  SHALL be the program-memory write address (32 entries).
REQ-006 Port prog_data  input  13  SHALL be the instruction word written: [12:11] opcode, [10:9] register, [8:0] data address.
REQ-007 Port prog_len  input  6  SHALL be the number of instructions to issue, 0..32; values above 32 are treated as 32.
REQ-008 Port start  input  1  SHALL be a run request, sampled in IDLE or DONE.
REQ-009 Port stop  input  1  SHALL be an abort request.
REQ-010 Port stall  input  1  SHALL be a hold request that defers the next issue.
REQ-011 Port instruction  output  13  SHALL carry the current instruction word to the vector processor; registered.
REQ-012 Port instr_valid  output  1  SHALL be high for exactly one cycle per issued instruction; registered.
REQ-013 Port pc  output  5  SHALL be the address of the instruction on the instruction output.
REQ-014 Port busy  output  1  SHALL be high in ISSUE and GAP.
REQ-015 Port done  output  1  SHALL be high in DONE.
REQ-016 Port err  output  1  SHALL be a sticky flag for a program write attempted while busy.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, GAP and DONE.
REQ-018 Program writes SHALL be accepted only in IDLE or DONE; prog_we while busy SHALL be ignored and SHALL set err.
REQ-019 Start sampled in IDLE or DONE with prog_len>0 and stop=0 SHALL clear pc and done and enter ISSUE.
  - Next cycle: instruction=mem[0] and instr_valid=1 (1-cycle latency).
REQ-020 Start with prog_len=0 SHALL go directly to DONE with no issue.
REQ-021 ISSUE SHALL last one cycle with instr_valid=1, then enter GAP for GAP cycles with instr_valid=0 and instruction/pc held.
  - With GAP=0, ISSUE SHALL repeat back-to-back.
REQ-022 After the last gap cycle, pc SHALL increment and the next ISSUE SHALL follow, giving one instruction per GAP+1 cycles.
REQ-023 Stall high at the edge where an issue would begin SHALL defer it; the sequencer SHALL hold in GAP with pc and instruction unchanged and instr_valid=0.
  - Stall SHALL NOT truncate an instruction already in ISSUE.
REQ-024 After the instruction at pc=prog_len-1 and its gap complete, the FSM SHALL enter DONE: done=1 and busy=0, held until start or reset.
REQ-025 Stop sampled in ISSUE or GAP SHALL force IDLE at the next edge: instr_valid=0, busy=0, done=0, pc unchanged.
REQ-026 Stop SHALL have priority over start and over stall when asserted in the same cycle.
REQ-027 The instruction output SHALL hold its last value while in IDLE or DONE.
REQ-028 prog_len SHALL be sampled at start and held internally for the run.

Reset
REQ-029 Reset SHALL force IDLE, pc=0, instruction=13'h0000, and instr_valid, busy, done and err all 0.
  - Reset SHALL override all other inputs, including mid-run.
REQ-030 Program memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro SEQ_LOOP_EN: when defined, completing instruction prog_len-1 and its gap SHALL wrap pc to 0 and issue again.
  - In this mode DONE is never entered from a run; only stop or reset ends it.
REQ-032 Without SEQ_LOOP_EN, the end-of-program behaviour SHALL be as specified in REQ-024.

Verification
REQ-033 Basic run: load {0x0005, 0x0A01, 0x1000, 0x0E07}, prog_len=4, GAP=1, start -> instr_valid pulses on cycles 1, 3, 5, 7 with those words in order; done=1 on cycle 9.
REQ-034 Stall: GAP=0, prog_len=3, stall high for 2 cycles after the first issue -> 2nd issue delayed 2 cycles; pc=1 held; no duplicate instr_valid.
REQ-035 Stop versus start: stop during the 2nd GAP -> IDLE next cycle, done=0; start and stop in the same IDLE cycle -> stays IDLE.
REQ-036 Write while busy: prog_we during a run -> memory unchanged (read back on a rerun), err=1 until reset.
REQ-037 Reset mid-run: reset asserted at pc=2 -> next cycle all outputs at reset values; rerun after reset issues the original program.
REQ-038 SEQ_LOOP_EN defined, prog_len=2, GAP=0 -> words alternate 0,1,0,1 with continuous instr_valid until stop; prog_len=0 -> DONE immediately in both builds.
